// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester round-robin arbiter driving a single memory bus,
// with per-access timeout and a recovery state that waits out a stale bus_ready.
module bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_done,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_done,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_re,
   output logic              bus_we,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              gnt_q, gnt_d;
   logic              re_q, re_d, we_q, we_d, busy_q, busy_d;
   logic              done0_q, done0_d, done1_q, done1_d, err0_q, err0_d, err1_q, err1_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              fire, fin, to, sel, sel_we;
   assign fire   = (state_q == IDLE) && (m0_req || m1_req);
   assign to     = (state_q == ACCESS) && !bus_ready && (cnt_q == 8'(TIMEOUT - 1));
   assign fin    = (state_q == ACCESS) && (bus_ready || to);
   // gnt_q doubles as the last-grant history; ties go to the other requester
   assign sel    = (m0_req && m1_req) ? !gnt_q : m1_req;
   assign sel_we = sel ? m1_we : m0_we;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         gnt_q    <= 1'b1;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         re_q     <= re_d;
         we_q     <= we_d;
         busy_q   <= busy_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (fire) state_d = ACCESS;
      else if (fin) state_d = RECOVER;
      else if (state_q == RECOVER && !bus_ready) state_d = IDLE;
      cnt_d = fire ? '0 : (state_q == ACCESS ? cnt_q + 8'd1 : cnt_q);
   end
   always_comb begin
      gnt_d    = fire ? sel : gnt_q;
      addr_d   = fire ? (sel ? m1_addr : m0_addr) : addr_q;
      wdata_d  = fire ? (sel ? m1_wdata : m0_wdata) : wdata_q;
      re_d     = fire ? !sel_we : (fin ? 1'b0 : re_q);
      we_d     = fire ? sel_we : (fin ? 1'b0 : we_q);
      done0_d  = fin && !gnt_q;
      done1_d  = fin && gnt_q;
      err0_d   = to && !gnt_q;
      err1_d   = to && gnt_q;
      rdata0_d = (fin && bus_ready && re_q && !gnt_q) ? bus_rdata : rdata0_q;
      rdata1_d = (fin && bus_ready && re_q && gnt_q) ? bus_rdata : rdata1_q;
      busy_d   = state_d != IDLE;
   end
   assign m0_done   = done0_q;
   assign m1_done   = done1_q;
   assign m0_err    = err0_q;
   assign m1_err    = err1_q;
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_re    = re_q;
   assign bus_we    = we_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of the bus arbiter with hand-computed expectations.
module tb_bus_arbiter;
   logic        clk = 1'b0, reset = 1'b0;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
   logic        bus_re, bus_we, busy;
   logic [31:0] bus_rdata = 0;
   logic        bus_ready = 0;
   int          vec = 0, errs = 0;

   bus_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_re(bus_re), .bus_we(bus_we),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      // reset state
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_re", bus_re, 0);
      check("rst_we", bus_we, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_rdata0", m0_rdata, 0);
      check("rst_done0", m0_done, 0);
      reset = 1'b1;
      // single read by m0, ready sampled two edges after the grant edge
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      @(negedge clk);
      m0_req = 0;
      check("rd_re", bus_re, 1);
      check("rd_we", bus_we, 0);
      check("rd_addr", bus_addr, 32'h10);
      check("rd_busy", busy, 1);
      @(negedge clk);
      check("rd_re2", bus_re, 1);
      check("rd_nodone", m0_done, 0);
      bus_ready = 1; bus_rdata = 32'hDEADBEEF;
      @(negedge clk);
      bus_ready = 0;
      check("rd_done", m0_done, 1);
      check("rd_err", m0_err, 0);
      check("rd_other", m1_done, 0);
      check("rd_re_off", bus_re, 0);
      check("rd_data", m0_rdata, 32'hDEADBEEF);
      @(negedge clk);
      check("rd_pulse", m0_done, 0);
      check("rd_idle", busy, 0);
      // write by m1; inputs changed mid-access must be ignored
      m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55AA55AA;
      @(negedge clk);
      m1_req = 0; m1_addr = 32'h99; m1_wdata = 32'h0;
      check("wr_we", bus_we, 1);
      check("wr_re", bus_re, 0);
      check("wr_addr", bus_addr, 32'h20);
      check("wr_wdata", bus_wdata, 32'h55AA55AA);
      @(negedge clk);
      check("wr_hold_addr", bus_addr, 32'h20);
      check("wr_hold_wdata", bus_wdata, 32'h55AA55AA);
      bus_ready = 1; bus_rdata = 32'h12345678;
      @(negedge clk);
      check("wr_done", m1_done, 1);
      check("wr_other", m0_done, 0);
      check("wr_we_off", bus_we, 0);
      check("wr_rdata", m1_rdata, 0);
      // stale ready held three extra cycles with m0 already requesting
      m0_req = 1; m0_we = 0; m0_addr = 32'h30;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stale_busy", busy, 1);
         check("stale_re", bus_re, 0);
         check("stale_done", m1_done, 0);
      end
      bus_ready = 0; bus_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      check("stale_idle", busy, 0);
      @(negedge clk);
      m0_req = 0;
      check("to_re", bus_re, 1);
      check("to_addr", bus_addr, 32'h30);
      // timeout: ready never arrives
      n = 0;
      while (bus_re && n < 40) begin
         check("to_nodone", m0_done, 0);
         @(negedge clk);
         n++;
      end
      check("to_len", n, 16);
      check("to_done", m0_done, 1);
      check("to_err", m0_err, 1);
      check("to_m1done", m1_done, 0);
      check("to_m1err", m1_err, 0);
      check("to_rdata", m0_rdata, 32'hDEADBEEF);
      @(negedge clk);
      check("to_pulse", m0_err, 0);
      check("to_idle", busy, 0);
      // tie from reset: grants alternate m0, m1, m0, m1
      reset = 0;
      m0_req = 1; m0_we = 0; m0_addr = 32'h100;
      m1_req = 1; m1_we = 0; m1_addr = 32'h200;
      #1;
      check("rst2_rdata0", m0_rdata, 0);
      @(negedge clk);
      reset = 1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!(bus_re || bus_we) && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("tie_addr", bus_addr, (k % 2) ? 32'h200 : 32'h100);
         check("tie_excl", bus_re & bus_we, 0);
         bus_ready = 1; bus_rdata = 32'hA0 + k;
         @(negedge clk);
         bus_ready = 0;
         check("tie_done0", m0_done, k % 2 == 0);
         check("tie_done1", m1_done, k % 2 == 1);
         check("tie_rdata", (k % 2) ? m1_rdata : m0_rdata, 32'hA0 + k);
      end
      m0_req = 0; m1_req = 0;
      @(negedge clk);
      @(negedge clk);
      check("tie_idle", busy, 0);
      // reset in the middle of an access
      m0_req = 1; m0_we = 0; m0_addr = 32'h300;
      @(negedge clk);
      m0_req = 0;
      check("ab_re", bus_re, 1);
      #2 reset = 0;
      #1;
      check("ab_re_off", bus_re, 0);
      check("ab_busy", busy, 0);
      check("ab_addr", bus_addr, 0);
      check("ab_rdata0", m0_rdata, 0);
      check("ab_rdata1", m1_rdata, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      check("ab_nodone", m0_done, 0);
      m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hCAFEF00D;
      @(negedge clk);
      m1_req = 0;
      check("ab_we", bus_we, 1);
      check("ab_waddr", bus_addr, 32'h40);
      check("ab_wdata", bus_wdata, 32'hCAFEF00D);
      bus_ready = 1;
      @(negedge clk);
      bus_ready = 0;
      check("ab_done1", m1_done, 1);
      check("ab_done0", m0_done, 0);
      check("ab_err1", m1_err, 0);
      @(negedge clk);
      check("ab_idle", busy, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
